// File: rtl/pc_update_unit_if.sv
// ----------------------------------------------------------------------------
// Module : pc_update_if
// Brief  : Control/datapath bundle between the CPU controller and the PC unit.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_update_if;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        zero;
  logic        gt;
  logic [2:0]  pc_source;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic [31:0] jump_target;
  logic [31:0] mem_data;
  logic        vec_valid;
  logic        epc_write;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic        misaligned_exc;
  logic        exc_busy;

  modport master (
    output pc_write, pc_write_cond, branch_op, zero, gt, pc_source,
           alu_result, alu_out, jump_target, mem_data, vec_valid, epc_write,
    input  pc_out, epc_out, misaligned_exc, exc_busy
  );

  modport slave (
    input  pc_write, pc_write_cond, branch_op, zero, gt, pc_source,
           alu_result, alu_out, jump_target, mem_data, vec_valid, epc_write,
    output pc_out, epc_out, misaligned_exc, exc_busy
  );
endinterface

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ----------------------------------------------------------------------------
// Module : pc_update_unit
// Brief  : PC/EPC registers with branch resolution and misaligned-target trap.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_update_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          VEC_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  pc_update_if.slave  bus
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_EXC_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_misaligned;

  logic        w_cond;
  logic        w_src_ok;
  logic [31:0] w_target;
  logic        w_take;
  logic        w_misaligned;
  logic [31:0] w_vector;

  always_comb begin
    w_cond = 1'b0;
    case (bus.branch_op)
      2'b00:   w_cond = bus.zero;
      2'b01:   w_cond = ~bus.zero;
      2'b10:   w_cond = ~bus.gt;
      default: w_cond = bus.gt;
    endcase
  end

  // Reserved source codes yield no valid target, which suppresses the write.
  always_comb begin
    w_target = r_pc;
    w_src_ok = 1'b1;
    case (bus.pc_source)
      3'd0:    w_target = bus.alu_result;
      3'd1:    w_target = bus.alu_out;
      3'd2:    w_target = bus.jump_target;
      3'd3:    w_target = r_epc;
      default: w_src_ok = 1'b0;
    endcase
  end

  assign w_take       = (bus.pc_write | (bus.pc_write_cond & w_cond)) & w_src_ok;
  assign w_misaligned = w_take & (w_target[1:0] != 2'b00);
  assign w_vector     = 32'(bus.mem_data[VEC_WIDTH-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_epc        <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_misaligned) begin
            r_epc        <= r_pc;
            r_misaligned <= 1'b1;
            r_state      <= ST_EXC_WAIT;
          end else begin
            if (w_take)
              r_pc <= w_target;
            if (bus.epc_write)
              r_epc <= bus.alu_result;
          end
        end
        default: begin
          if (bus.vec_valid) begin
            r_pc    <= w_vector;
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign bus.pc_out         = r_pc;
  assign bus.epc_out        = r_epc;
  assign bus.misaligned_exc = r_misaligned;
  assign bus.exc_busy       = (r_state == ST_EXC_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_pc_update_unit
// Brief  : Scoreboard bench for pc_update_unit against a behavioural model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_update_unit;

  logic clk;
  logic rst;

  pc_update_if bus ();

  pc_update_unit #(
    .RESET_PC  (32'h0000_0000),
    .VEC_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Architectural model: what the PC, EPC and trap status must be.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_waiting;

  task automatic model_reset();
    m_pc      = 32'h0;
    m_epc     = 32'h0;
    m_waiting = 1'b0;
  endtask

  task automatic drive(input bit pw, input bit pwc, input logic [1:0] bop,
                       input bit z, input bit g, input logic [2:0] src,
                       input logic [31:0] alu, input logic [31:0] aout,
                       input logic [31:0] jt, input logic [31:0] md,
                       input bit vv, input bit ew);
    exp_t        e;
    bit          branch_ok;
    bit          take;
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic [31:0] n_epc;
    bit          n_exc;
    @(negedge clk);
    bus.pc_write = pw;     bus.pc_write_cond = pwc; bus.branch_op = bop;
    bus.zero = z;          bus.gt = g;              bus.pc_source = src;
    bus.alu_result = alu;  bus.alu_out = aout;      bus.jump_target = jt;
    bus.mem_data = md;     bus.vec_valid = vv;      bus.epc_write = ew;

    n_pc  = m_pc;
    n_epc = m_epc;
    n_exc = 1'b0;
    if (m_waiting) begin
      if (vv) begin
        n_pc      = md % 256;
        m_waiting = 1'b0;
      end
    end else begin
      branch_ok = (bop == 0) ? z : (bop == 1) ? !z : (bop == 2) ? !g : g;
      take = (pw || (pwc && branch_ok)) && (src <= 3);
      tgt  = (src == 0) ? alu : (src == 1) ? aout : (src == 2) ? jt : m_epc;
      if (take && (tgt % 4 != 0)) begin
        n_epc     = m_pc;
        n_exc     = 1'b1;
        m_waiting = 1'b1;
      end else begin
        if (take) n_pc = tgt;
        if (ew)   n_epc = alu;
      end
    end
    m_pc  = n_pc;
    m_epc = n_epc;
    e.pc = n_pc; e.epc = n_epc; e.exc = n_exc; e.busy = m_waiting;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 2'b00, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  // Monitor: every clock the DUT presents a new register state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.pc_out !== e.pc || bus.epc_out !== e.epc ||
            bus.misaligned_exc !== e.exc || bus.exc_busy !== e.busy) begin
          miscompares++;
          $display("FAIL cycle_state t=%0t: got pc=%h epc=%h exc=%b busy=%b, want pc=%h epc=%h exc=%b busy=%b",
                   $time, bus.pc_out, bus.epc_out, bus.misaligned_exc, bus.exc_busy,
                   e.pc, e.epc, e.exc, e.busy);
        end
      end
    end
  end

  task automatic check_reset(input string name);
    vectors++;
    if (bus.pc_out !== 32'h0 || bus.epc_out !== 32'h0 ||
        bus.exc_busy !== 1'b0 || bus.misaligned_exc !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got pc=%h epc=%h busy=%b exc=%b, want all zero",
               name, bus.pc_out, bus.epc_out, bus.exc_busy, bus.misaligned_exc);
    end
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset(name);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] r_jt;
  logic [31:0] r_aout;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.pc_write = 0; bus.pc_write_cond = 0; bus.branch_op = 0; bus.zero = 0;
    bus.gt = 0; bus.pc_source = 0; bus.alu_result = 0; bus.alu_out = 0;
    bus.jump_target = 0; bus.mem_data = 0; bus.vec_valid = 0; bus.epc_write = 0;
    model_reset();
    #3 check_reset("initial_reset");
    @(negedge clk);
    rst = 1'b0;

    // Unconditional writes from ALU result and jump target.
    drive(1, 0, 2'b00, 0, 0, 3'd0, 32'h4, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 3'd2, 32'h0, 32'h0, 32'h0040_0010, 32'h0, 0, 0);
    // Branch conditions against alu_out = 0x100.
    drive(0, 1, 2'b00, 1, 0, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 3'd0, 32'h8, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(0, 1, 2'b00, 0, 0, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    drive(0, 1, 2'b01, 1, 0, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    drive(0, 1, 2'b11, 0, 1, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 3'd0, 32'hC, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(0, 1, 2'b10, 0, 1, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    drive(0, 1, 2'b10, 0, 0, 3'd1, 32'h0, 32'h100, 32'h0, 32'h0, 0, 0);
    // Misaligned jump from PC 0x20, ignored writes while waiting, then vector.
    drive(1, 0, 2'b00, 0, 0, 3'd0, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 3'd2, 32'h0, 32'h0, 32'h0000_0102, 32'h0, 0, 1);
    drive(1, 0, 2'b00, 0, 0, 3'd0, 32'h44, 32'h0, 32'h0, 32'h0, 0, 1);
    drive(0, 1, 2'b00, 1, 0, 3'd1, 32'h0, 32'h200, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF7C, 1, 0);
    idle();
    // EPC load followed by return-from-exception.
    drive(0, 0, 2'b00, 0, 0, 3'd0, 32'h50, 32'h0, 32'h0, 32'h0, 0, 1);
    drive(1, 0, 2'b00, 0, 0, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    // Reserved source and vec_valid outside a trap.
    drive(1, 0, 2'b00, 0, 0, 3'd5, 32'h3, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0000_0088, 1, 0);
    // Trap entry, then asynchronous reset while waiting for the vector.
    drive(1, 0, 2'b00, 0, 0, 3'd1, 32'h0, 32'h0000_0301, 32'h0, 32'h0, 0, 0);
    idle();
    async_reset("reset_mid_exc_wait");
    idle();

    for (int i = 0; i < 600; i++) begin
      r_jt   = $urandom;
      r_aout = $urandom;
      if ($urandom_range(0, 3) != 0) r_jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) r_aout[1:0] = 2'b00;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            2'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) > 7) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, r_aout, r_jt,
            $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
